// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Sits between the execute stage and the branch predictor. Every accepted
// branch resolution is checked against the prediction made at fetch. A
// mispredict produces a registered one-cycle redirect to fetch. Every accepted
// resolution, mispredicted or not, is pushed into a small FIFO of predictor
// training updates. The FIFO drains one entry per cycle onto the predictor's
// update port.
//
// Handshakes:
//   resolve  : an entry transfers at a rising edge where
//              resolve_valid_i && resolve_ready_o. ready depends only on the
//              registered occupancy, never on the dequeue side.
//   update   : the head entry transfers (pops) at a rising edge where
//              update_valid_o is high. update_valid_o is already masked by
//              update_hold_i, so the predictor holds off by raising hold.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   resolve_valid_i/ready_o     resolution handshake from execute
//   resolve_pc_i/taken_i/target_i   resolved branch outcome
//   pred_taken_i/pred_target_i  prediction made at fetch
//   redirect_valid_o/pc_o       one-cycle redirect pulse and correct next PC
//   update_hold_i               predictor stall
//   update_valid_o/pc_o/taken_o/target_o  predictor training update (FIFO head)
//   branch_count_o              saturating count of accepted resolutions
//   mispredict_count_o          saturating count of accepted mispredicts

module branch_resolve_unit #(
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 resolve_valid_i,
    output logic                 resolve_ready_o,
    input  logic [63:0]          resolve_pc_i,
    input  logic                 resolve_taken_i,
    input  logic [63:0]          resolve_target_i,
    input  logic                 pred_taken_i,
    input  logic [63:0]          pred_target_i,
    output logic                 redirect_valid_o,
    output logic [63:0]          redirect_pc_o,
    input  logic                 update_hold_i,
    output logic                 update_valid_o,
    output logic [63:0]          update_pc_o,
    output logic                 update_taken_o,
    output logic [63:0]          update_target_o,
    output logic [CNT_WIDTH-1:0] branch_count_o,
    output logic [CNT_WIDTH-1:0] mispredict_count_o
);

    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = 64 + 1 + 64;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(QUEUE_DEPTH);

    logic [ENTRY_W-1:0]   r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [OCC_W-1:0]     r_occ;
    logic                 r_redirect_valid;
    logic [63:0]          r_redirect_pc;
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispred_cnt;

    logic                 w_accept;
    logic                 w_pop;
    logic                 w_mispredict;
    logic [63:0]          w_correct_pc;
    logic [ENTRY_W-1:0]   w_head;

    // Ready comes from registered occupancy only: a full queue refuses a new
    // entry even in a cycle where the head is popping.
    assign resolve_ready_o = (r_occ != OCC_FULL);
    assign w_accept        = resolve_valid_i && resolve_ready_o;

    assign update_valid_o  = (r_occ != '0) && !update_hold_i;
    assign w_pop           = update_valid_o;

    // A taken/taken pair with differing targets is also a mispredict; a
    // not-taken/not-taken pair never is, whatever the targets say.
    assign w_mispredict = (resolve_taken_i != pred_taken_i) ||
                          (resolve_taken_i && pred_taken_i &&
                           (resolve_target_i != pred_target_i));

    // 64-bit wraparound on the fall-through PC is intentional.
    assign w_correct_pc = resolve_taken_i ? resolve_target_i
                                          : (resolve_pc_i + 64'd4);

    assign w_head = r_mem[r_rd_ptr];
    assign {update_pc_o, update_taken_o, update_target_o} = w_head;

    assign redirect_valid_o   = r_redirect_valid;
    assign redirect_pc_o      = r_redirect_pc;
    assign branch_count_o     = r_branch_cnt;
    assign mispredict_count_o = r_mispred_cnt;

    // Storage carries no reset; emptiness is tracked by the occupancy alone.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {resolve_pc_i, resolve_taken_i, resolve_target_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Redirect PC keeps its last value between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_accept && w_mispredict;
            if (w_accept && w_mispredict) begin
                r_redirect_pc <= w_correct_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_accept && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
            end
            if (w_accept && w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus a randomized run,
// all checked against a queue-based reference model. A second instance with
// 4-bit counters covers saturation.

module tb_branch_resolve_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- main DUT signals ----------------
    logic        resolve_valid_i, resolve_ready_o;
    logic [63:0] resolve_pc_i, resolve_target_i, pred_target_i;
    logic        resolve_taken_i, pred_taken_i;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;
    logic        update_hold_i, update_valid_o, update_taken_o;
    logic [63:0] update_pc_o, update_target_o;
    logic [31:0] branch_count_o, mispredict_count_o;

    branch_resolve_unit #(.QUEUE_DEPTH(4), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .resolve_valid_i(resolve_valid_i), .resolve_ready_o(resolve_ready_o),
        .resolve_pc_i(resolve_pc_i), .resolve_taken_i(resolve_taken_i),
        .resolve_target_i(resolve_target_i), .pred_taken_i(pred_taken_i),
        .pred_target_i(pred_target_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .update_hold_i(update_hold_i), .update_valid_o(update_valid_o),
        .update_pc_o(update_pc_o), .update_taken_o(update_taken_o),
        .update_target_o(update_target_o),
        .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
    );

    // ---------------- saturation DUT signals ----------------
    logic        s_valid, s_ready, s_taken, s_ptaken, s_rv, s_uv, s_utaken;
    logic [63:0] s_pc, s_target, s_ptarget, s_rpc, s_upc, s_utarget;
    logic [3:0]  s_bc, s_mc;

    branch_resolve_unit #(.QUEUE_DEPTH(4), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .resolve_valid_i(s_valid), .resolve_ready_o(s_ready),
        .resolve_pc_i(s_pc), .resolve_taken_i(s_taken),
        .resolve_target_i(s_target), .pred_taken_i(s_ptaken),
        .pred_target_i(s_ptarget),
        .redirect_valid_o(s_rv), .redirect_pc_o(s_rpc),
        .update_hold_i(1'b0), .update_valid_o(s_uv),
        .update_pc_o(s_upc), .update_taken_o(s_utaken),
        .update_target_o(s_utarget),
        .branch_count_o(s_bc), .mispredict_count_o(s_mc)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
    } upd_t;

    upd_t        mq[$];
    logic [31:0] exp_bc, exp_mc;
    logic        exp_rv;
    logic [63:0] exp_rpc;

    // values seen just before the edge of the last drive_cycle
    logic obs_ready, obs_uv, exp_ready, exp_uv, last_accept;
    upd_t obs_head, exp_head;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_n = 1'b0;
        resolve_valid_i = 1'b0; update_hold_i = 1'b0;
        @(posedge clk);
        mq.delete();
        exp_bc = '0; exp_mc = '0; exp_rv = 1'b0; exp_rpc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Drives one cycle from just after a falling edge, samples the
    // combinational outputs, advances the model across the rising edge,
    // and returns at the next falling edge.
    task automatic drive_cycle(input logic v, input logic [63:0] pc,
                               input logic tk, input logic [63:0] tg,
                               input logic ptk, input logic [63:0] ptg,
                               input logic hold);
        logic mis;
        upd_t e;
        resolve_valid_i = v; resolve_pc_i = pc; resolve_taken_i = tk;
        resolve_target_i = tg; pred_taken_i = ptk; pred_target_i = ptg;
        update_hold_i = hold;
        #1;
        obs_ready = resolve_ready_o;
        obs_uv    = update_valid_o;
        obs_head  = {update_pc_o, update_taken_o, update_target_o};
        exp_ready = (mq.size() < 4);
        exp_uv    = (mq.size() > 0) && !hold;
        exp_head  = (mq.size() > 0) ? mq[0] : '0;
        last_accept = v && exp_ready;
        @(posedge clk);
        if (exp_uv) void'(mq.pop_front());
        exp_rv = 1'b0;
        if (last_accept) begin
            e.pc = pc; e.taken = tk; e.target = tg;
            mq.push_back(e);
            if (exp_bc != 32'hFFFF_FFFF) exp_bc++;
            mis = (tk != ptk) || (tk && ptk && (tg != ptg));
            if (mis) begin
                if (exp_mc != 32'hFFFF_FFFF) exp_mc++;
                exp_rv  = 1'b1;
                exp_rpc = tk ? tg : pc + 64'd4;
            end
        end
        @(negedge clk);
        resolve_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && mq.size() > 0; i++)
            drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (resolve_ready_o !== 1'b1 || update_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: ready=%b uv=%b, want ready=1 uv=0",
                     resolve_ready_o, update_valid_o);
        end
        n_checks++;
        if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 64'h0 ||
            branch_count_o !== 32'h0 || mispredict_count_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: rv=%b rpc=%h bc=%0d mc=%0d, want all 0",
                     redirect_valid_o, redirect_pc_o, branch_count_o, mispredict_count_o);
        end
    endtask

    task automatic test_basic();
        drive_cycle(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1, 64'h2000, 1'b0);
        n_checks++;
        if (obs_uv !== 1'b0) begin
            n_fail++; $display("FAIL basic_no_bypass: uv=%b want 0", obs_uv);
        end
        n_checks++;
        if (redirect_valid_o !== 1'b0 || branch_count_o !== 32'd1 ||
            mispredict_count_o !== 32'd0) begin
            n_fail++;
            $display("FAIL basic_counts: rv=%b bc=%0d mc=%0d want 0/1/0",
                     redirect_valid_o, branch_count_o, mispredict_count_o);
        end
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        n_checks++;
        if (obs_uv !== 1'b1 || obs_head.pc !== 64'h1000 || obs_head.taken !== 1'b1 ||
            obs_head.target !== 64'h2000) begin
            n_fail++;
            $display("FAIL basic_update: uv=%b pc=%h tk=%b tg=%h want 1/1000/1/2000",
                     obs_uv, obs_head.pc, obs_head.taken, obs_head.target);
        end
    endtask

    task automatic test_mispredict();
        drive_cycle(1'b1, 64'h1000, 1'b0, 64'h2000, 1'b1, 64'h2000, 1'b0);
        n_checks++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'h1004 ||
            mispredict_count_o !== 32'd1) begin
            n_fail++;
            $display("FAIL dir_mispredict: rv=%b rpc=%h mc=%0d want 1/1004/1",
                     redirect_valid_o, redirect_pc_o, mispredict_count_o);
        end
        drive_cycle(1'b1, 64'h1000, 1'b1, 64'h3000, 1'b1, 64'h2000, 1'b0);
        n_checks++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'h3000 ||
            mispredict_count_o !== 32'd2) begin
            n_fail++;
            $display("FAIL tgt_mispredict: rv=%b rpc=%h mc=%0d want 1/3000/2",
                     redirect_valid_o, redirect_pc_o, mispredict_count_o);
        end
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        n_checks++;
        if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 64'h3000) begin
            n_fail++;
            $display("FAIL redirect_hold: rv=%b rpc=%h want 0/3000",
                     redirect_valid_o, redirect_pc_o);
        end
        drain();
    endtask

    task automatic test_hold_full();
        logic [63:0] got[$];
        logic        done5;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 64'h100 + 64'(4 * i), 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
            n_checks++;
            if (obs_ready !== 1'b1) begin
                n_fail++; $display("FAIL hold_fill_ready %0d: ready=%b want 1", i, obs_ready);
            end
        end
        drive_cycle(1'b1, 64'h110, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        n_checks++;
        if (obs_ready !== 1'b0 || obs_uv !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_full: ready=%b uv=%b want 0/0", obs_ready, obs_uv);
        end
        done5 = 1'b0;
        for (int c = 0; c < 12 && (mq.size() > 0 || !done5); c++) begin
            drive_cycle(!done5, 64'h110, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
            if (last_accept) done5 = 1'b1;
            if (obs_uv) got.push_back(obs_head.pc);
            n_checks++;
            if (obs_uv !== exp_uv || (exp_uv && obs_head !== exp_head)) begin
                n_fail++;
                $display("FAIL hold_drain c%0d: uv=%b head=%h want uv=%b head=%h",
                         c, obs_uv, obs_head.pc, exp_uv, exp_head.pc);
            end
        end
        n_checks++;
        if (got.size() != 5 || got[0] !== 64'h100 || got[1] !== 64'h104 ||
            got[2] !== 64'h108 || got[3] !== 64'h10C || got[4] !== 64'h110) begin
            n_fail++;
            $display("FAIL hold_order: got %0d updates, want 100,104,108,10C,110", got.size());
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, 64'h200 + 64'(4 * i), 1'b1, 64'h800, 1'b1, 64'h800, 1'b1);
        drive_cycle(1'b1, 64'h210, 1'b1, 64'h800, 1'b1, 64'h800, 1'b0);
        n_checks++;
        if (obs_ready !== 1'b0 || obs_uv !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop: ready=%b uv=%b want 0/1", obs_ready, obs_uv);
        end
        drive_cycle(1'b1, 64'h210, 1'b1, 64'h800, 1'b1, 64'h800, 1'b1);
        n_checks++;
        if (obs_ready !== 1'b1 || obs_head.pc !== 64'h204) begin
            n_fail++;
            $display("FAIL full_pop_next: ready=%b head=%h want 1/204", obs_ready, obs_head.pc);
        end
        drain();
    endtask

    task automatic test_edge_reset();
        drive_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h5000, 1'b1, 64'h5000, 1'b0);
        n_checks++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: rv=%b rpc=%h want 1/0", redirect_valid_o, redirect_pc_o);
        end
        drain();
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 64'h300 + 64'(4 * i), 1'b1, 64'h0, 1'b0, 64'h0, 1'b1);
        apply_reset();
        n_checks++;
        if (update_valid_o !== 1'b0 || resolve_ready_o !== 1'b1 || redirect_valid_o !== 1'b0 ||
            branch_count_o !== 32'd0 || mispredict_count_o !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: uv=%b ready=%b rv=%b bc=%0d mc=%0d want 0/1/0/0/0",
                     update_valid_o, resolve_ready_o, redirect_valid_o,
                     branch_count_o, mispredict_count_o);
        end
    endtask

    task automatic test_random();
        logic        v, tk, ptk, hold;
        logic [63:0] pc, tg, ptg;
        for (int c = 0; c < 400; c++) begin
            v    = ($urandom_range(0, 9) < 7);
            hold = ($urandom_range(0, 9) < 4);
            tk   = $urandom_range(0, 1);
            ptk  = ($urandom_range(0, 3) == 0) ? !tk : tk;
            pc   = {$urandom, $urandom} & ~64'h3;
            tg   = {32'h0, $urandom} & ~64'h3;
            ptg  = ($urandom_range(0, 3) == 0) ? tg ^ 64'h40 : tg;
            drive_cycle(v, pc, tk, tg, ptk, ptg, hold);
            n_checks++;
            if (obs_ready !== exp_ready || obs_uv !== exp_uv ||
                (exp_uv && obs_head !== exp_head)) begin
                n_fail++;
                $display("FAIL rand_queue c%0d: ready=%b uv=%b head=%h want %b/%b/%h",
                         c, obs_ready, obs_uv, obs_head.pc, exp_ready, exp_uv, exp_head.pc);
            end
            n_checks++;
            if (redirect_valid_o !== exp_rv || redirect_pc_o !== exp_rpc ||
                branch_count_o !== exp_bc || mispredict_count_o !== exp_mc) begin
                n_fail++;
                $display("FAIL rand_regs c%0d: rv=%b rpc=%h bc=%0d mc=%0d want %b/%h/%0d/%0d",
                         c, redirect_valid_o, redirect_pc_o, branch_count_o,
                         mispredict_count_o, exp_rv, exp_rpc, exp_bc, exp_mc);
            end
        end
        drain();
    endtask

    task automatic test_saturation();
        int n_acc = 0;
        int exp_s;
        s_taken = 1'b0; s_ptaken = 1'b1; s_target = 64'h40; s_ptarget = 64'h40;
        for (int i = 0; i < 25; i++) begin
            s_valid = 1'b1;
            s_pc    = 64'h1000 + 64'(4 * i);
            #1;
            if (s_ready) n_acc++;
            @(posedge clk);
            @(negedge clk);
            s_valid = 1'b0;
            exp_s = (n_acc > 15) ? 15 : n_acc;
            if (i == 9 || i == 19 || i == 24) begin
                n_checks++;
                if (s_bc !== 4'(exp_s) || s_mc !== 4'(exp_s)) begin
                    n_fail++;
                    $display("FAIL sat_cnt i%0d: bc=%h mc=%h want %h", i, s_bc, s_mc, 4'(exp_s));
                end
            end
        end
        n_checks++;
        if (n_acc != 25) begin
            n_fail++; $display("FAIL sat_accepts: %0d accepted, want 25", n_acc);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        resolve_valid_i = 1'b0; resolve_pc_i = '0; resolve_taken_i = 1'b0;
        resolve_target_i = '0; pred_taken_i = 1'b0; pred_target_i = '0;
        update_hold_i = 1'b0;
        s_valid = 1'b0; s_pc = '0; s_taken = 1'b0; s_target = '0;
        s_ptaken = 1'b0; s_ptarget = '0;
        test_reset();
        test_basic();
        test_mispredict();
        test_hold_full();
        test_full_pop();
        test_edge_reset();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits between the execute stage and the branch predictor.
- Accepts resolved branch outcomes from execute, each carrying the prediction made at fetch.
- Detects mispredictions and issues a one-cycle redirect to fetch.
- Buffers predictor training updates in a small FIFO and drains them one per cycle onto the predictor's update interface (update_valid/pc/taken/target).

Parameters:
- QUEUE_DEPTH, 4, number of buffered predictor updates; power of two, minimum 2.
- CNT_WIDTH, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- resolve_valid_i  in  1  execute presents a resolved branch
- resolve_ready_o  out  1  unit accepts the resolution this cycle
- resolve_pc_i  in  64  branch PC
- resolve_taken_i  in  1  actual direction
- resolve_target_i  in  64  computed branch target, valid even when not taken
- pred_taken_i  in  1  direction predicted at fetch
- pred_target_i  in  64  target predicted at fetch
- redirect_valid_o  out  1  one-cycle redirect pulse to fetch
- redirect_pc_o  out  64  correct next PC
- update_hold_i  in  1  predictor cannot take an update this cycle
- update_valid_o  out  1  predictor update strobe
- update_pc_o  out  64  update PC
- update_taken_o  out  1  update direction
- update_target_o  out  64  update target
- branch_count_o  out  CNT_WIDTH  resolved branches accepted
- mispredict_count_o  out  CNT_WIDTH  mispredictions detected

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low (rst_n); all state updates on the rising edge of clk.
- Reset (rst_n low at a clock edge):
  - Queue emptied; read/write pointers and occupancy set to 0.
  - redirect_valid_o=0, redirect_pc_o=0, both counters=0.
  - update_valid_o=0, since the queue is empty.
  - Reset mid-operation discards all queued updates and any pending redirect.
- Accept rule:
  - A resolution is accepted when resolve_valid_i && resolve_ready_o at a clock edge.
  - resolve_ready_o = (occupancy != QUEUE_DEPTH), driven from registered occupancy only.
  - No combinational path from the dequeue side to ready; a full queue does not accept even if it pops in the same cycle.
- Mispredict detection (combinational on accepted inputs):
  - mispredict = (resolve_taken_i != pred_taken_i) || (resolve_taken_i && pred_taken_i && resolve_target_i != pred_target_i).
  - Correct PC = resolve_taken_i ? resolve_target_i : resolve_pc_i + 4. Addition is 64-bit modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
- Redirect:
  - Registered. If a resolution accepted at edge N mispredicts, redirect_valid_o=1 and redirect_pc_o=correct PC during the cycle after edge N, for exactly one cycle.
  - Back-to-back mispredicts give back-to-back pulses, each with its own PC.
  - redirect_pc_o holds its last value when redirect_valid_o=0.
- Update queue:
  - Every accepted resolution is enqueued as {resolve_pc_i, resolve_taken_i, resolve_target_i}, mispredicted or not; the predictor counter must also learn not-taken outcomes.
  - Head presentation is combinational: update_valid_o = !empty && !update_hold_i; update_pc/taken/target_o = head entry.
  - The head pops at the edge where update_valid_o=1.
  - Minimum latency is acceptance at edge N, update visible in the cycle after N. There is no same-cycle bypass.
  - Simultaneous enqueue and dequeue leaves occupancy unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Order is strictly FIFO.
  - While update_hold_i=1, the head is held and stable.
- Counters:
  - branch_count_o increments on each accept.
  - mispredict_count_o increments on each accepted mispredict.
  - Both saturate at all-ones and never wrap.

Test Plan:
1. Reset, then accept pc=0x1000, taken=1, target=0x2000, pred_taken=1, pred_target=0x2000 -> no redirect; next cycle update_valid_o=1 with pc=0x1000, taken=1, target=0x2000; branch_count_o=1, mispredict_count_o=0.
2. Direction mispredict: pc=0x1000, taken=0, pred_taken=1 -> redirect_valid_o=1 for one cycle with redirect_pc_o=0x1004; mispredict_count_o=1. Target mispredict: taken=1, target=0x3000, pred_target=0x2000 -> redirect_pc_o=0x3000.
3. Hold update_hold_i=1 and issue 5 consecutive resolutions, pc=0x100,0x104,0x108,0x10C,0x110 -> ready drops after the 4th accept and the 5th waits; release hold -> updates emerge in order, one per cycle, then the 5th is accepted and follows.
4. Full queue with simultaneous pop: ready=0 that cycle, occupancy goes 4->3, ready=1 next cycle.
5. Edge cases: not-taken branch at pc=0xFFFF_FFFF_FFFF_FFFC, pred_taken=1 -> redirect_pc_o=0x0. Assert rst_n=0 with 3 queued entries -> next cycle update_valid_o=0, resolve_ready_o=1, counters=0.
6. Force counters to all-ones via a CNT_WIDTH=4 instance and 20 mispredicts -> both counters read 0xF and remain there.
